// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS-subset control FSM: states, opcodes,
// funct codes, ALU ops and datapath mux selects.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_IF    = 4'd0,
    S_ID    = 4'd1,
    S_MADDR = 4'd2,
    S_MRD   = 4'd3,
    S_MWB   = 4'd4,
    S_MWR   = 4'd5,
    S_REX   = 4'd6,
    S_RWB   = 4'd7,
    S_BR    = 4'd8,
    S_J     = 4'd9,
    S_IEX   = 4'd10,
    S_IWB   = 4'd11,
    S_JR    = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0a;
  localparam logic [5:0] OP_ANDI  = 6'h0c;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_XORI  = 6'h0e;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [5:0] F_SLL = 6'h00;
  localparam logic [5:0] F_SRL = 6'h02;
  localparam logic [5:0] F_JR  = 6'h08;
  localparam logic [5:0] F_ADD = 6'h20;
  localparam logic [5:0] F_SUB = 6'h22;
  localparam logic [5:0] F_AND = 6'h24;
  localparam logic [5:0] F_OR  = 6'h25;
  localparam logic [5:0] F_XOR = 6'h26;
  localparam logic [5:0] F_SLT = 6'h2a;

  localparam logic [2:0] ALU_AND   = 3'b000;
  localparam logic [2:0] ALU_OR    = 3'b001;
  localparam logic [2:0] ALU_ADD   = 3'b010;
  localparam logic [2:0] ALU_XOR   = 3'b011;
  localparam logic [2:0] ALU_SHIFT = 3'b101;
  localparam logic [2:0] ALU_SUB   = 3'b110;
  localparam logic [2:0] ALU_SLT   = 3'b111;

  localparam logic [1:0] MTR_ALUOUT = 2'b00;
  localparam logic [1:0] MTR_MDR    = 2'b01;
  localparam logic [1:0] MTR_PC     = 2'b10;

  localparam logic [1:0] RD_RT = 2'b00;
  localparam logic [1:0] RD_RD = 2'b01;
  localparam logic [1:0] RD_RA = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_A     = 2'b01;
  localparam logic [1:0] SRCA_SHAMT = 2'b10;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCS_ALU    = 2'b00;
  localparam logic [1:0] PCS_ALUOUT = 2'b01;
  localparam logic [1:0] PCS_JUMP   = 2'b10;
  localparam logic [1:0] PCS_REG    = 2'b11;

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational next-state logic and R/I-type ALU-op decode for the multi-cycle
// controller. mem_done gates leaving the memory states (tied high without waits).
module mc_ctrl_decode
  import mc_ctrl_pkg::*;
(
  input  state_t     state,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       mem_done,
  output state_t     next_state,
  output logic       bad_instr,
  output logic [2:0] r_alu_op,
  output logic [2:0] i_alu_op,
  output logic       shift_op,
  output logic       zero_ext,
  output logic       lui_op
);

  logic r_ok;
  logic i_ok;

  // NOTE: every output of a combinational block gets a default first, so no path
  // through the case statements can leave a value held and infer a latch.
  always_comb begin
    r_alu_op = ALU_ADD;
    shift_op = 1'b0;
    r_ok     = 1'b1;
    case (funct)
      F_ADD:        r_alu_op = ALU_ADD;
      F_SUB:        r_alu_op = ALU_SUB;
      F_AND:        r_alu_op = ALU_AND;
      F_OR:         r_alu_op = ALU_OR;
      F_XOR:        r_alu_op = ALU_XOR;
      F_SLT:        r_alu_op = ALU_SLT;
      F_SLL, F_SRL: begin
        r_alu_op = ALU_SHIFT;
        shift_op = 1'b1;
      end
      F_JR:         r_alu_op = ALU_ADD;
      default:      r_ok = 1'b0;
    endcase
  end

  always_comb begin
    i_alu_op = ALU_ADD;
    zero_ext = 1'b0;
    lui_op   = 1'b0;
    i_ok     = 1'b1;
    case (opcode)
      OP_ADDI: i_alu_op = ALU_ADD;
      OP_SLTI: i_alu_op = ALU_SLT;
      OP_ANDI: begin i_alu_op = ALU_AND; zero_ext = 1'b1; end
      OP_ORI:  begin i_alu_op = ALU_OR;  zero_ext = 1'b1; end
      OP_XORI: begin i_alu_op = ALU_XOR; zero_ext = 1'b1; end
      OP_LUI:  begin i_alu_op = ALU_ADD; lui_op = 1'b1; end
      default: i_ok = 1'b0;
    endcase
  end

  always_comb begin
    next_state = S_IF;
    bad_instr  = 1'b0;
    case (state)
      S_ID: begin
        case (opcode)
          OP_RTYPE: begin
            if (!r_ok)              bad_instr  = 1'b1;
            else if (funct == F_JR) next_state = S_JR;
            else                    next_state = S_REX;
          end
          OP_LW, OP_SW:   next_state = S_MADDR;
          OP_BEQ, OP_BNE: next_state = S_BR;
          OP_J, OP_JAL:   next_state = S_J;
          default: begin
            if (i_ok) next_state = S_IEX;
            else      bad_instr  = 1'b1;
          end
        endcase
      end
      S_MADDR: next_state = (opcode == OP_LW) ? S_MRD : S_MWR;
      S_MRD:   next_state = mem_done ? S_MWB : S_MRD;
      S_MWR:   next_state = mem_done ? S_IF : S_MWR;
      S_REX:   next_state = S_RWB;
      S_IEX:   next_state = S_IWB;
      S_MWB, S_RWB, S_BR, S_J, S_IWB, S_JR: next_state = S_IF;
      // S_IF and the unused codes 13-15 all behave as fetch.
      default: next_state = mem_done ? S_ID : S_IF;
    endcase
  end

endmodule

// File: rtl/multi_cycle_control.sv
// Moore control FSM for the shared-memory, shared-ALU multi-cycle datapath.
// Define MC_CTRL_MEM_WAIT_EN to make fetch/load/store wait on mem_ready with a timeout.
module multi_cycle_control
  import mc_ctrl_pkg::*;
#(
  parameter int WAIT_MAX = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       bne,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic [1:0] mem_to_reg,
  output logic [1:0] reg_dst,
  output logic       reg_write,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_op,
  output logic       imm_zero_ext,
  output logic       lui,
  output logic [1:0] pc_source,
  output logic       illegal,
  output logic [3:0] state
);

  state_t     cur_state, next_state;
  logic       mem_done, timeout, bad_instr;
  logic       shift_op, zero_ext, lui_op;
  logic [2:0] r_alu_op, i_alu_op;

  mc_ctrl_decode u_decode (
    .state      (cur_state),
    .opcode     (opcode),
    .funct      (funct),
    .mem_done   (mem_done),
    .next_state (next_state),
    .bad_instr  (bad_instr),
    .r_alu_op   (r_alu_op),
    .i_alu_op   (i_alu_op),
    .shift_op   (shift_op),
    .zero_ext   (zero_ext),
    .lui_op     (lui_op)
  );

`ifdef MC_CTRL_MEM_WAIT_EN
  localparam logic [3:0] WAIT_LAST = 4'(WAIT_MAX - 1);

  logic [3:0] wait_cnt;
  logic       mem_state;

  assign mem_state = (cur_state == S_IF) || (cur_state == S_MRD) || (cur_state == S_MWR);
  assign mem_done  = mem_ready;
  assign timeout   = mem_state && !mem_ready && (wait_cnt == WAIT_LAST);

  // Counts cycles spent in the current memory state; any state change restarts it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                   wait_cnt <= '0;
    else if (timeout || next_state != cur_state) wait_cnt <= '0;
    else if (mem_state)                           wait_cnt <= wait_cnt + 4'd1;
  end
`else
  logic unused_mem;

  assign mem_done   = 1'b1;
  assign timeout    = 1'b0;
  assign unused_mem = mem_ready & (WAIT_MAX != 0);
`endif

  // NOTE: sequential state uses non-blocking assignments so every register in the
  // design updates from the same pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       cur_state <= S_IF;
    else if (timeout) cur_state <= S_IF;
    else              cur_state <= next_state;
  end

  // Outputs decode the state register only (plus IR fields), so reset takes effect
  // on every strobe immediately and an abandoned instruction cannot write anything.
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    bne           = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = MTR_ALUOUT;
    reg_dst       = RD_RT;
    reg_write     = 1'b0;
    alu_src_a     = SRCA_PC;
    alu_src_b     = SRCB_B;
    alu_op        = ALU_AND;
    imm_zero_ext  = 1'b0;
    lui           = 1'b0;
    pc_source     = PCS_ALU;
    case (cur_state)
      S_ID: begin
        alu_src_b = SRCB_IMM_SH;
        alu_op    = ALU_ADD;
      end
      S_MADDR: begin
        alu_src_a = SRCA_A;
        alu_src_b = SRCB_IMM;
        alu_op    = ALU_ADD;
      end
      S_MRD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
      end
      S_MWB: begin
        reg_write  = 1'b1;
        mem_to_reg = MTR_MDR;
      end
      S_MWR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
      end
      S_REX: begin
        alu_src_a = shift_op ? SRCA_SHAMT : SRCA_A;
        alu_op    = r_alu_op;
      end
      S_RWB: begin
        reg_write = 1'b1;
        reg_dst   = RD_RD;
      end
      S_BR: begin
        alu_src_a     = SRCA_A;
        alu_op        = ALU_SUB;
        pc_write_cond = 1'b1;
        pc_source     = PCS_ALUOUT;
        bne           = (opcode == OP_BNE);
      end
      S_J: begin
        pc_write  = 1'b1;
        pc_source = PCS_JUMP;
        if (opcode == OP_JAL) begin
          reg_write  = 1'b1;
          reg_dst    = RD_RA;
          mem_to_reg = MTR_PC;
        end
      end
      S_IEX, S_IWB: begin
        alu_op       = i_alu_op;
        imm_zero_ext = zero_ext;
        lui          = lui_op;
        if (cur_state == S_IEX) begin
          alu_src_a = SRCA_A;
          alu_src_b = SRCB_IMM;
        end else begin
          reg_write = 1'b1;
        end
      end
      S_JR: begin
        alu_src_a = SRCA_A;
        pc_write  = 1'b1;
        pc_source = PCS_REG;
      end
      default: begin
        mem_read  = 1'b1;
        ir_write  = mem_done;
        pc_write  = mem_done;
        alu_src_b = SRCB_FOUR;
        alu_op    = ALU_ADD;
      end
    endcase
    illegal = bad_instr | timeout;
  end

  assign state = cur_state;

endmodule

// File: tb/tb_multi_cycle_control.sv
// Scoreboard bench for multi_cycle_control: stimulus queues the expected control
// word for every cycle of an instruction, a negedge monitor pops and compares.
module tb_multi_cycle_control;

  typedef struct packed {
    logic [3:0] st;
    logic       pc_write, pc_write_cond, bne, iord, mem_read, mem_write, ir_write;
    logic [1:0] mem_to_reg, reg_dst;
    logic       reg_write;
    logic [1:0] alu_src_a, alu_src_b;
    logic [2:0] alu_op;
    logic       imm_zero_ext, lui;
    logic [1:0] pc_source;
    logic       illegal;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode, funct;
  logic       mem_ready;
  logic       pc_write, pc_write_cond, bne, iord, mem_read, mem_write, ir_write;
  logic [1:0] mem_to_reg, reg_dst, alu_src_a, alu_src_b, pc_source;
  logic       reg_write, imm_zero_ext, lui, illegal;
  logic [2:0] alu_op;
  logic [3:0] state;

  vec_t  q_vec[$];
  string q_name[$];
  int    checks = 0;
  int    errors = 0;

  multi_cycle_control dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .bne(bne), .iord(iord),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .imm_zero_ext(imm_zero_ext), .lui(lui), .pc_source(pc_source),
    .illegal(illegal), .state(state)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %07h expected %07h", nm, act, exp);
    end
  endtask

  function automatic vec_t sample();
    vec_t v;
    v.st = state;             v.pc_write = pc_write;   v.pc_write_cond = pc_write_cond;
    v.bne = bne;              v.iord = iord;           v.mem_read = mem_read;
    v.mem_write = mem_write;  v.ir_write = ir_write;   v.mem_to_reg = mem_to_reg;
    v.reg_dst = reg_dst;      v.reg_write = reg_write; v.alu_src_a = alu_src_a;
    v.alu_src_b = alu_src_b;  v.alu_op = alu_op;       v.imm_zero_ext = imm_zero_ext;
    v.lui = lui;              v.pc_source = pc_source; v.illegal = illegal;
    return v;
  endfunction

  function automatic vec_t v_if();
    vec_t v = '0;
    v.st = 4'd0; v.mem_read = 1'b1; v.ir_write = 1'b1; v.pc_write = 1'b1;
    v.alu_src_b = 2'b01; v.alu_op = 3'b010;
    return v;
  endfunction

  function automatic vec_t v_id();
    vec_t v = '0;
    v.st = 4'd1; v.alu_src_b = 2'b11; v.alu_op = 3'b010;
    return v;
  endfunction

  task automatic push(input vec_t v, input string nm);
    q_vec.push_back(v);
    q_name.push_back(nm);
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // R-type ALU instruction: IF, ID, REX, RWB
  task automatic rtype(input string nm, input logic [5:0] fn, input logic [1:0] srca,
                       input logic [2:0] op);
    vec_t v;
    opcode = 6'h00; funct = fn;
    push(v_if(), {nm, "_if"});
    push(v_id(), {nm, "_id"});
    v = '0; v.st = 4'd6; v.alu_src_a = srca; v.alu_op = op;
    push(v, {nm, "_rex"});
    v = '0; v.st = 4'd7; v.reg_write = 1'b1; v.reg_dst = 2'b01;
    push(v, {nm, "_rwb"});
    cycles(4);
  endtask

  // I-type ALU instruction: IF, ID, IEX, IWB
  task automatic itype(input string nm, input logic [5:0] op, input logic [2:0] aop,
                       input logic zx, input logic lu);
    vec_t v;
    opcode = op; funct = 6'h11;
    push(v_if(), {nm, "_if"});
    push(v_id(), {nm, "_id"});
    v = '0; v.st = 4'd10; v.alu_src_a = 2'b01; v.alu_src_b = 2'b10;
    v.alu_op = aop; v.imm_zero_ext = zx; v.lui = lu;
    push(v, {nm, "_iex"});
    v = '0; v.st = 4'd11; v.reg_write = 1'b1; v.alu_op = aop; v.imm_zero_ext = zx; v.lui = lu;
    push(v, {nm, "_iwb"});
    cycles(4);
  endtask

  // Three-cycle control-transfer instruction: IF, ID, then the given state word.
  task automatic short3(input string nm, input logic [5:0] op, input logic [5:0] fn,
                        input vec_t last);
    opcode = op; funct = fn;
    push(v_if(), {nm, "_if"});
    push(v_id(), {nm, "_id"});
    push(last, {nm, "_ex"});
    cycles(3);
  endtask

  task automatic bad(input string nm, input logic [5:0] op, input logic [5:0] fn);
    vec_t v;
    opcode = op; funct = fn;
    push(v_if(), {nm, "_if"});
    v = v_id(); v.illegal = 1'b1;
    push(v, {nm, "_id"});
    cycles(2);
  endtask

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (q_vec.size() != 0) begin
        vec_t  e;
        string n;
        e = q_vec.pop_front();
        n = q_name.pop_front();
        check(n, 32'(sample()), 32'(e));
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    vec_t v;
    rst_n = 1'b0; opcode = 6'h00; funct = 6'h20; mem_ready = 1'b1;
    #2;
    check("rst_state", 32'(state), 32'd0);
    check("rst_reg_write", 32'(reg_write), 32'd0);
    check("rst_mem_read", 32'(mem_read), 32'd1);
    check("rst_ir_write", 32'(ir_write), 32'd1);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;

    rtype("add", 6'h20, 2'b01, 3'b010);
    rtype("sub", 6'h22, 2'b01, 3'b110);
    rtype("sll", 6'h00, 2'b10, 3'b101);
    rtype("slt", 6'h2a, 2'b01, 3'b111);

    // lw: IF, ID, MADDR, MRD, MWB
    opcode = 6'h23; funct = 6'h00;
    push(v_if(), "lw_if");
    push(v_id(), "lw_id");
    v = '0; v.st = 4'd2; v.alu_src_a = 2'b01; v.alu_src_b = 2'b10; v.alu_op = 3'b010;
    push(v, "lw_maddr");
    v = '0; v.st = 4'd3; v.mem_read = 1'b1; v.iord = 1'b1;
    push(v, "lw_mrd");
    v = '0; v.st = 4'd4; v.reg_write = 1'b1; v.mem_to_reg = 2'b01;
    push(v, "lw_mwb");
    cycles(5);

    // sw: IF, ID, MADDR, MWR
    opcode = 6'h2b;
    push(v_if(), "sw_if");
    push(v_id(), "sw_id");
    v = '0; v.st = 4'd2; v.alu_src_a = 2'b01; v.alu_src_b = 2'b10; v.alu_op = 3'b010;
    push(v, "sw_maddr");
    v = '0; v.st = 4'd5; v.mem_write = 1'b1; v.iord = 1'b1;
    push(v, "sw_mwr");
    cycles(4);

    v = '0; v.st = 4'd8; v.alu_src_a = 2'b01; v.alu_op = 3'b110;
    v.pc_write_cond = 1'b1; v.pc_source = 2'b01; v.bne = 1'b1;
    short3("bne", 6'h05, 6'h00, v);
    v.bne = 1'b0;
    short3("beq", 6'h04, 6'h00, v);
    v = '0; v.st = 4'd9; v.pc_write = 1'b1; v.pc_source = 2'b10;
    short3("j", 6'h02, 6'h00, v);
    v.reg_write = 1'b1; v.reg_dst = 2'b10; v.mem_to_reg = 2'b10;
    short3("jal", 6'h03, 6'h00, v);
    v = '0; v.st = 4'd12; v.alu_src_a = 2'b01; v.pc_write = 1'b1; v.pc_source = 2'b11;
    short3("jr", 6'h00, 6'h08, v);

    itype("ori",  6'h0d, 3'b001, 1'b1, 1'b0);
    itype("lui",  6'h0f, 3'b010, 1'b0, 1'b1);
    itype("slti", 6'h0a, 3'b111, 1'b0, 1'b0);
    itype("addi", 6'h08, 3'b010, 1'b0, 1'b0);

    bad("bad_op", 6'h3f, 6'h00);
    bad("bad_funct", 6'h00, 6'h3f);
    push(v_if(), "after_bad_if");
    push(v_id(), "after_bad_id");
    opcode = 6'h02;
    v = '0; v.st = 4'd9; v.pc_write = 1'b1; v.pc_source = 2'b10;
    push(v, "after_bad_j");
    cycles(3);

    // Reset asserted in the middle of a load's read cycle.
    opcode = 6'h23;
    push(v_if(), "rst_lw_if");
    push(v_id(), "rst_lw_id");
    v = '0; v.st = 4'd2; v.alu_src_a = 2'b01; v.alu_src_b = 2'b10; v.alu_op = 3'b010;
    push(v, "rst_lw_maddr");
    v = '0; v.st = 4'd3; v.mem_read = 1'b1; v.iord = 1'b1;
    push(v, "rst_lw_mrd");
    cycles(3);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_state", 32'(state), 32'd0);
    check("midrst_reg_write", 32'(reg_write), 32'd0);
    check("midrst_iord", 32'(iord), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    check("postrst_mem_read", 32'(mem_read), 32'd1);
    check("postrst_ir_write", 32'(ir_write), 32'd1);
    rtype("post_rst_xor", 6'h26, 2'b01, 3'b011);

`ifdef MC_CTRL_MEM_WAIT_EN
    // mem_ready held low in fetch: 14 waiting cycles, then a timeout pulse.
    mem_ready = 1'b0;
    for (int i = 0; i < 15; i++) begin
      v = '0; v.st = 4'd0; v.mem_read = 1'b1; v.alu_src_b = 2'b01; v.alu_op = 3'b010;
      v.illegal = (i == 14);
      push(v, "wait_if");
    end
    cycles(15);
    mem_ready = 1'b1;
    rtype("after_timeout_and", 6'h24, 2'b01, 3'b000);
`endif

    for (int i = 0; i < 10 && q_vec.size() != 0; i++) @(negedge clk);
    #1;
    check("queue_drained", 32'(q_vec.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
